// File: rtl/rmii_rx_byte_assembler.sv
// ---------------------------------------------------------------------------
// rmii_rx_byte_assembler : RMII dibit oversampler -> 9-bit {last, byte} stream
// Option macro: RMII_RX_ERROR_ABORT_EN (RX_ER aborts the frame).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rmii_rx_byte_assembler #(
  parameter int SAMPLES_PER_DIBIT_FAST = 2,
  parameter int SAMPLES_PER_DIBIT_SLOW = 20,
  parameter int SPEED_THRESHOLD        = 200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] data,
  input  logic       data_enable,
  input  logic       data_error,
  output logic [1:0] speed_code,
  output logic [8:0] packaged_data,
  output logic       packaged_data_valid
);

  localparam int PH_W  = ($clog2(SAMPLES_PER_DIBIT_SLOW) > 0) ? $clog2(SAMPLES_PER_DIBIT_SLOW) : 1;
  localparam int LEN_W = $clog2(SPEED_THRESHOLD + 1);

  localparam logic [PH_W-1:0]  C_FAST_LAST = PH_W'(SAMPLES_PER_DIBIT_FAST - 1);
  localparam logic [PH_W-1:0]  C_SLOW_LAST = PH_W'(SAMPLES_PER_DIBIT_SLOW - 1);
  localparam logic [PH_W-1:0]  C_FAST_HALF = PH_W'(SAMPLES_PER_DIBIT_FAST / 2);
  localparam logic [PH_W-1:0]  C_SLOW_HALF = PH_W'(SAMPLES_PER_DIBIT_SLOW / 2);
  localparam logic [LEN_W-1:0] C_THRESH    = LEN_W'(SPEED_THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DRAIN    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             fast_q, fast_d;
  logic             skip_q, skip_d;
  logic [1:0]       dcnt_q, dcnt_d;
  logic [5:0]       shreg_q, shreg_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [1:0]       speed_q, speed_d;
  logic [8:0]       pdata_q, pdata_d;
  logic             pvalid_q, pvalid_d;

  logic [PH_W-1:0]  w_last_ph;
  logic [PH_W-1:0]  w_half_ph;
  logic             w_sample;
  logic             w_sfd_fast;
  logic [PH_W-1:0]  w_sfd_last;

`ifndef RMII_RX_ERROR_ABORT_EN
  logic unused_data_error;
  assign unused_data_error = data_error;
`endif

  assign w_last_ph  = fast_q ? C_FAST_LAST : C_SLOW_LAST;
  assign w_half_ph  = fast_q ? C_FAST_HALF : C_SLOW_HALF;
  assign w_sample   = (state_q == S_DATA) && (phase_q == w_half_ph);
  assign w_sfd_fast = (len_q < C_THRESH);
  assign w_sfd_last = w_sfd_fast ? C_FAST_LAST : C_SLOW_LAST;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    phase_d      = phase_q;
    fast_d       = fast_q;
    skip_d       = skip_q;
    dcnt_d       = dcnt_q;
    shreg_d      = shreg_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    speed_d      = speed_q;
    pdata_d      = pdata_q;
    pvalid_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_enable) begin
          state_d      = S_PREAMBLE;
          len_d        = '0;
          pend_valid_d = 1'b0;
        end
      end

      S_PREAMBLE: begin
        if (len_q < C_THRESH) len_d = len_q + 1'b1;
        if (!data_enable) begin
          state_d = S_IDLE;
        end
`ifdef RMII_RX_ERROR_ABORT_EN
        else if (data_error) begin
          state_d = S_DRAIN;
        end
`endif
        else if (data == 2'b11) begin
          // This clock is phase 0 of the SFD dibit; the next clock is phase 1.
          state_d = S_DATA;
          fast_d  = w_sfd_fast;
          speed_d = w_sfd_fast ? 2'b10 : 2'b01;
          phase_d = (w_sfd_last == '0) ? '0 : PH_W'(1);
          skip_d  = 1'b1;
          dcnt_d  = 2'd0;
        end
      end

      S_DATA: begin
        phase_d = (phase_q == w_last_ph) ? '0 : phase_q + 1'b1;
        if (w_sample) begin
`ifdef RMII_RX_ERROR_ABORT_EN
          if (data_error) begin
            pend_valid_d = 1'b0;
            state_d      = S_DRAIN;
          end else
`endif
          if (!data_enable) begin
            if (pend_valid_q) begin
              pdata_d  = {1'b1, pend_q};
              pvalid_d = 1'b1;
            end
            pend_valid_d = 1'b0;
            state_d      = S_IDLE;
          end else if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            shreg_d = {data, shreg_q[5:2]};
            dcnt_d  = dcnt_q + 2'd1;
            if (dcnt_q == 2'd3) begin
              // A byte is only known not to be last once its successor completes.
              if (pend_valid_q) begin
                pdata_d  = {1'b0, pend_q};
                pvalid_d = 1'b1;
              end
              pend_d       = {data, shreg_q};
              pend_valid_d = 1'b1;
            end
          end
        end
      end

      S_DRAIN: begin
        if (!data_enable) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      phase_q      <= '0;
      fast_q       <= 1'b0;
      skip_q       <= 1'b0;
      dcnt_q       <= 2'd0;
      shreg_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      speed_q      <= 2'b00;
      pdata_q      <= '0;
      pvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      phase_q      <= phase_d;
      fast_q       <= fast_d;
      skip_q       <= skip_d;
      dcnt_q       <= dcnt_d;
      shreg_q      <= shreg_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      speed_q      <= speed_d;
      pdata_q      <= pdata_d;
      pvalid_q     <= pvalid_d;
    end
  end

  assign speed_code          = speed_q;
  assign packaged_data       = pdata_q;
  assign packaged_data_valid = pvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_rmii_rx_byte_assembler.sv
// ---------------------------------------------------------------------------
// tb_rmii_rx_byte_assembler : randomized frame bench with a byte-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rmii_rx_byte_assembler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] data;
  logic       data_enable;
  logic       data_error;
  logic [1:0] speed_code;
  logic [8:0] packaged_data;
  logic       packaged_data_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx[$];
  logic [8:0] got[$];
  logic       prev_valid = 1'b0;
  logic [1:0] model_speed = 2'b00;

  rmii_rx_byte_assembler dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .data                (data),
    .data_enable         (data_enable),
    .data_error          (data_error),
    .speed_code          (speed_code),
    .packaged_data       (packaged_data),
    .packaged_data_valid (packaged_data_valid)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (packaged_data_valid) begin
      got.push_back(packaged_data);
      n_tests++;
      if (prev_valid) begin
        n_fail++;
        $display("FAIL single_cycle_valid: valid high on consecutive clocks, got %b required 0", prev_valid);
      end
    end
    prev_valid = packaged_data_valid;
  end

  // Speed from the preamble length: 31 dibits precede the SFD's final dibit.
  function automatic logic [1:0] speed_of(input int n);
    return ((31 * n) < 200) ? 2'b10 : 2'b01;
  endfunction

  task automatic hold(input logic [1:0] d, input logic de, input int n);
    data        = d;
    data_enable = de;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_preamble(input int n);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = (i == 7) ? 8'hD5 : 8'h55;
      for (int k = 0; k < 4; k++) hold(b[2*k +: 2], 1'b1, n);
    end
  endtask

  task automatic send_frame(input int n, input int partial, input int err_dibit, input int tail);
    logic [7:0] b;
    int di;
    di = 0;
    data_error = 1'b0;
    send_preamble(n);
    foreach (tx[i]) begin
      b = tx[i];
      for (int k = 0; k < 4; k++) begin
        data_error = (di == err_dibit);
        hold(b[2*k +: 2], 1'b1, n);
        di++;
      end
    end
    for (int p = 0; p < partial; p++) begin
      data_error = (di == err_dibit);
      hold(2'($urandom), 1'b1, n);
      di++;
    end
    data_error = 1'b0;
    hold(2'($urandom), 1'b0, tail);
  endtask

  task automatic check_frame(input string name, input int n, input int err_dibit);
    logic [8:0] exp_q[$];
    int  keep;
    int  complete;
    logic has_last;
    keep     = tx.size();
    has_last = 1'b1;
`ifdef RMII_RX_ERROR_ABORT_EN
    if (err_dibit >= 0) begin
      complete = (err_dibit / 4 < tx.size()) ? err_dibit / 4 : tx.size();
      keep     = (complete > 0) ? complete - 1 : 0;
      has_last = 1'b0;
    end
`else
    complete = err_dibit;
`endif
    for (int i = 0; i < keep; i++)
      exp_q.push_back({has_last && (i == keep - 1), tx[i]});
    model_speed = speed_of(n);

    n_tests++;
    if (got.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_byte%0d: got 0x%03h, required 0x%03h", name, i, got[i], exp_q[i]);
      end
    end
    n_tests++;
    if (speed_code !== model_speed) begin
      n_fail++;
      $display("FAIL %s_speed: got %b, required %b", name, speed_code, model_speed);
    end
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    data        = 2'b00;
    data_enable = 1'b0;
    data_error  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_tests += 3;
    if (speed_code !== 2'b00) begin
      n_fail++; $display("FAIL reset_speed: got %b, required 00", speed_code);
    end
    if (packaged_data !== 9'h000) begin
      n_fail++; $display("FAIL reset_data: got 0x%03h, required 0x000", packaged_data);
    end
    if (packaged_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b, required 0", packaged_data_valid);
    end
    reset_n = 1'b1;
    hold(2'b00, 1'b0, 3);
  endtask

  task automatic test_fast;
    tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    got.delete();
    send_frame(2, 0, -1, 8);
    check_frame("fast", 2, -1);
  endtask

  task automatic test_slow;
    tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    got.delete();
    send_frame(20, 0, -1, 80);
    check_frame("slow", 20, -1);
  endtask

  task automatic test_partial;
    tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    got.delete();
    send_frame(2, 2, -1, 8);
    check_frame("partial", 2, -1);
  endtask

  task automatic test_preamble_abort;
    got.delete();
    for (int i = 0; i < 10; i++) hold(2'b01, 1'b1, 2);
    hold(2'b00, 1'b0, 20);
    n_tests += 2;
    if (got.size() != 0) begin
      n_fail++; $display("FAIL preamble_abort_count: got %0d bytes, required 0", got.size());
    end
    if (speed_code !== model_speed) begin
      n_fail++; $display("FAIL preamble_abort_speed: got %b, required %b", speed_code, model_speed);
    end
  endtask

  task automatic test_back_to_back;
    tx = '{8'h11};
    got.delete();
    send_frame(2, 0, -1, 4);
    check_frame("b2b_first", 2, -1);
    tx = '{8'h22, 8'h33};
    got.delete();
    send_frame(2, 0, -1, 4);
    check_frame("b2b_second", 2, -1);
  endtask

  task automatic test_error;
    tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    got.delete();
    send_frame(2, 0, 9, 8);
    check_frame("error", 2, 9);
    tx = '{8'h5A, 8'hC3};
    got.delete();
    send_frame(2, 0, -1, 8);
    check_frame("after_error", 2, -1);
  endtask

  task automatic test_mid_reset;
    got.delete();
    send_preamble(2);
    for (int i = 0; i < 6; i++) hold(2'($urandom), 1'b1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    model_speed = 2'b00;
    n_tests += 3;
    if (packaged_data_valid !== 1'b0 || packaged_data !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_reset_out: got valid=%b data=0x%03h, required 0 0x000", packaged_data_valid, packaged_data);
    end
    if (speed_code !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_speed: got %b, required 00", speed_code);
    end
    hold(2'b01, 1'b1, 4);
    reset_n = 1'b1;
    hold(2'b00, 1'b0, 10);
    if (got.size() != 0) begin
      n_fail++; $display("FAIL mid_reset_count: got %0d bytes, required 0", got.size());
    end
  endtask

  task automatic test_random;
    int n;
    int len;
    int partial;
    for (int f = 0; f < 8; f++) begin
      n       = ($urandom_range(0, 1) == 0) ? 2 : 20;
      len     = $urandom_range(0, 5);
      partial = $urandom_range(0, 3);
      tx.delete();
      for (int i = 0; i < len; i++) tx.push_back(8'($urandom));
      got.delete();
      send_frame(n, partial, -1, 4 * n);
      check_frame($sformatf("random%0d", f), n, -1);
    end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_slow();
    test_partial();
    test_preamble_abort();
    test_back_to_back();
    test_error();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
